// File: rtl/proc_control.sv
// Control unit for the 16-bit processor: fetches a 9-bit instruction and
// sequences datapath strobes through time steps T0..T3.
module proc_control (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [15:0] i_din,
  output logic        o_irin_c,
  output logic [7:0]  o_rin_c,
  output logic [7:0]  o_rout_c,
  output logic        o_dinout_c,
  output logic        o_gout_c,
  output logic        o_ain_c,
  output logic        o_gin_c,
  output logic        o_addsub_c,
  output logic        o_done_c,
  output logic [1:0]  o_tstep
);

  localparam int unsigned IR_W  = 9;
  localparam int unsigned REG_N = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t            r_step;
  step_t            w_step_next;
  logic [IR_W-1:0]  r_ir;
  logic [2:0]       w_op;
  logic [2:0]       w_rx;
  logic [2:0]       w_ry;
  logic             w_unused_din;

  assign w_op         = r_ir[8:6];
  assign w_rx         = r_ir[5:3];
  assign w_ry         = r_ir[2:0];
  assign o_tstep      = r_step;
  assign w_unused_din = ^i_din[6:0];

  // Step counter
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_step <= T0;
    else         r_step <= w_step_next;
  end

  // Instruction register, loaded only on a fetch in T0
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                   r_ir <= '0;
    else if (r_step == T0 && i_run) r_ir <= i_din[15:7];
  end

  // Next-step and strobe decode
  always_comb begin
    w_step_next = r_step;
    o_irin_c    = 1'b0;
    o_rin_c     = '0;
    o_rout_c    = '0;
    o_dinout_c  = 1'b0;
    o_gout_c    = 1'b0;
    o_ain_c     = 1'b0;
    o_gin_c     = 1'b0;
    o_addsub_c  = 1'b0;
    o_done_c    = 1'b0;
    case (r_step)
      T0: begin
        // Reset forces T0 asynchronously; gate the fetch strobe too
        o_irin_c = i_run & ~i_reset;
        if (i_run) w_step_next = T1;
      end
      T1: begin
        case (w_op)
          3'b000: begin
            o_rout_c = REG_N'(1) << w_ry;
            o_rin_c  = REG_N'(1) << w_rx;
            o_done_c = 1'b1;
          end
          3'b001: begin
            o_dinout_c = 1'b1;
            o_rin_c    = REG_N'(1) << w_rx;
            o_done_c   = 1'b1;
          end
          3'b010, 3'b011: begin
            o_rout_c = REG_N'(1) << w_rx;
            o_ain_c  = 1'b1;
          end
          default: o_done_c = 1'b1;
        endcase
        w_step_next = o_done_c ? T0 : T2;
      end
      T2: begin
        o_rout_c    = REG_N'(1) << w_ry;
        o_gin_c     = 1'b1;
        o_addsub_c  = w_op[0];
        w_step_next = T3;
      end
      default: begin
        o_gout_c    = 1'b1;
        o_rin_c     = REG_N'(1) << w_rx;
        o_done_c    = 1'b1;
        w_step_next = T0;
      end
    endcase
  end

endmodule
